// File: rtl/kuznechik_key_schedule_pkg.sv
// Kuznechik constants shared by the key schedule: sizes, FSM states, the pi S-box,
// the l-vector, the F[C] helper functions and the iteration constants C1..C32.
package kuznechik_pkg;
  localparam int BLK_W    = 128;
  localparam int NUM_KEYS = 10;
  localparam int ITERS    = 32;

  typedef enum logic [1:0] {IDLE, PUT, WAIT_L, SERVE} ks_state_e;

  localparam logic [7:0] KUZ_PI [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  // Coefficient for byte k of the block (k = 0 is the least significant byte).
  localparam logic [7:0] KUZ_LVEC [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  // GF(2^8) multiply modulo x^8 + x^7 + x^6 + x + 1.
  function automatic logic [7:0] kuz_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hc3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [BLK_W-1:0] kuz_x(input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] k);
    return a ^ k;
  endfunction

  function automatic logic [BLK_W-1:0] kuz_s(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = KUZ_PI[x[8*k +: 8]];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] kuz_r(input logic [BLK_W-1:0] x);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++) acc = acc ^ kuz_gf_mul(x[8*k +: 8], KUZ_LVEC[k]);
    return {acc, x[BLK_W-1:8]};
  endfunction

  function automatic logic [BLK_W-1:0] kuz_l(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = x;
    for (int k = 0; k < 16; k++) y = kuz_r(y);
    return y;
  endfunction

  // C_i = L(Vec128(i)), folded to constants at elaboration.
  localparam logic [BLK_W-1:0] KUZ_C [1:32] = '{
    kuz_l(128'd1),  kuz_l(128'd2),  kuz_l(128'd3),  kuz_l(128'd4),
    kuz_l(128'd5),  kuz_l(128'd6),  kuz_l(128'd7),  kuz_l(128'd8),
    kuz_l(128'd9),  kuz_l(128'd10), kuz_l(128'd11), kuz_l(128'd12),
    kuz_l(128'd13), kuz_l(128'd14), kuz_l(128'd15), kuz_l(128'd16),
    kuz_l(128'd17), kuz_l(128'd18), kuz_l(128'd19), kuz_l(128'd20),
    kuz_l(128'd21), kuz_l(128'd22), kuz_l(128'd23), kuz_l(128'd24),
    kuz_l(128'd25), kuz_l(128'd26), kuz_l(128'd27), kuz_l(128'd28),
    kuz_l(128'd29), kuz_l(128'd30), kuz_l(128'd31), kuz_l(128'd32)
  };
endpackage

// File: rtl/kuznechik_key_schedule_if.sv
// Load / serve bus between the key schedule (slave) and its controller and encrypt core (master).
// KUZ_KS_DECRYPT_ORDER_EN adds key_dir.
interface kuznechik_key_schedule_if;
  import kuznechik_pkg::*;

  logic               key_load;
  logic [2*BLK_W-1:0] master_key;
  logic               key_rewind;
  logic               key_next;
`ifdef KUZ_KS_DECRYPT_ORDER_EN
  logic               key_dir;
`endif
  logic [BLK_W-1:0]   round_key;
  logic               key_valid;
  logic               busy;
  logic               keys_ready;

  modport master (
    output key_load, master_key, key_rewind, key_next,
`ifdef KUZ_KS_DECRYPT_ORDER_EN
    output key_dir,
`endif
    input  round_key, key_valid, busy, keys_ready
  );

  modport slave (
    input  key_load, master_key, key_rewind, key_next,
`ifdef KUZ_KS_DECRYPT_ORDER_EN
    input  key_dir,
`endif
    output round_key, key_valid, busy, keys_ready
  );
endinterface

// File: rtl/kuznechik_ks_feistel.sv
// One Feistel step F[C]: a1_new = L(S(a1 ^ c)) ^ a0. L runs as 16 serial R rounds,
// so ready pulses 17 cycles after put; a new put restarts the step.
module kuznechik_ks_feistel
  import kuznechik_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             put,
  input  logic [BLK_W-1:0] a1,
  input  logic [BLK_W-1:0] a0,
  input  logic [BLK_W-1:0] c,
  output logic             ready,
  output logic [BLK_W-1:0] a1_new
);
  logic             run_p0;
  logic [3:0]       rnd_p0;
  logic [BLK_W-1:0] lx_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p0 <= 1'b0;
      rnd_p0 <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (put) begin
        run_p0 <= 1'b1;
        rnd_p0 <= '0;
      end else if (run_p0) begin
        rnd_p0 <= rnd_p0 + 4'd1;
        if (rnd_p0 == 4'd15) begin
          run_p0 <= 1'b0;
          ready  <= 1'b1;
        end
      end
    end
  end

  // p0: X and S on put, then one R round per cycle
  always_ff @(posedge clk) begin
    if (put)         lx_p0 <= kuz_s(kuz_x(a1, c));
    else if (run_p0) lx_p0 <= kuz_r(lx_p0);
  end

  assign a1_new = lx_p0 ^ a0;
endmodule

// File: rtl/kuznechik_key_schedule.sv
// Kuznechik key schedule: expands a 256-bit master key into K1..K10 and serves one per key_next.
// Define KUZ_KS_DECRYPT_ORDER_EN to add key_dir, which selects K10..K1 serving order.
module kuznechik_key_schedule
  import kuznechik_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  kuznechik_key_schedule_if.slave ks
);
  ks_state_e        state;
  logic [5:0]       iter;
  logic [3:0]       ptr, ptr_now, ptr_adv, key_idx;
  logic             dir_q, dir_in, dir_now;
  logic [BLK_W-1:0] keys [NUM_KEYS];
  logic [BLK_W-1:0] a1, a0, a1_new, c_cur;
  logic             f_put, f_ready;
  logic [BLK_W-1:0] round_key_q;
  logic             key_valid_q, busy_q, keys_ready_q;

`ifdef KUZ_KS_DECRYPT_ORDER_EN
  assign dir_in = ks.key_dir;
`else
  assign dir_in = 1'b0;
`endif

  function automatic logic [3:0] start_ptr(input logic dir);
    return dir ? 4'(NUM_KEYS - 1) : 4'd0;
  endfunction

  function automatic logic [3:0] advance(input logic [3:0] p, input logic dir);
    if (dir) return (p == 4'd0) ? 4'(NUM_KEYS - 1) : p - 4'd1;
    return (p == 4'(NUM_KEYS - 1)) ? 4'd0 : p + 4'd1;
  endfunction

  // A rewind in the same cycle as key_next takes effect before the key is picked.
  always_comb begin
    dir_now = ks.key_rewind ? dir_in : dir_q;
    ptr_now = ks.key_rewind ? start_ptr(dir_in) : ptr;
    ptr_adv = advance(ptr_now, dir_now);
    key_idx = {iter[5:3], 1'b0};
  end

  assign f_put = (state == PUT);
  assign c_cur = KUZ_C[iter];

  kuznechik_ks_feistel u_feistel (
    .clk    (clk),
    .rst_n  (rst_n),
    .put    (f_put),
    .a1     (a1),
    .a0     (a0),
    .c      (c_cur),
    .ready  (f_ready),
    .a1_new (a1_new)
  );

  always_ff @(posedge clk) begin
    if (ks.key_load) begin
      a1 <= ks.master_key[2*BLK_W-1:BLK_W];
      a0 <= ks.master_key[BLK_W-1:0];
    end else if (state == WAIT_L && f_ready) begin
      a1 <= a1_new;
      a0 <= a1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      iter         <= '0;
      ptr          <= '0;
      dir_q        <= 1'b0;
      round_key_q  <= '0;
      key_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) keys[k] <= '0;
    end else begin
      key_valid_q <= 1'b0;
      if (ks.key_load) begin
        keys[0]      <= ks.master_key[2*BLK_W-1:BLK_W];
        keys[1]      <= ks.master_key[BLK_W-1:0];
        iter         <= 6'd1;
        busy_q       <= 1'b1;
        keys_ready_q <= 1'b0;
        state        <= PUT;
      end else begin
        if (ks.key_rewind) begin
          ptr   <= ptr_now;
          dir_q <= dir_now;
        end
        case (state)
          PUT: state <= WAIT_L;
          WAIT_L: begin
            if (f_ready) begin
              // every eighth iteration yields the next round-key pair
              if (iter[2:0] == 3'd0) begin
                keys[key_idx]        <= a1_new;
                keys[key_idx + 4'd1] <= a1;
              end
              if (iter == 6'(ITERS)) begin
                busy_q       <= 1'b0;
                keys_ready_q <= 1'b1;
                ptr          <= start_ptr(dir_in);
                dir_q        <= dir_in;
                state        <= SERVE;
              end else begin
                iter  <= iter + 6'd1;
                state <= PUT;
              end
            end
          end
          SERVE: begin
            if (ks.key_next) begin
              round_key_q <= keys[ptr_now];
              key_valid_q <= 1'b1;
              ptr         <= ptr_adv;
              dir_q       <= dir_now;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ks.round_key  = round_key_q;
  assign ks.key_valid  = key_valid_q;
  assign ks.busy       = busy_q;
  assign ks.keys_ready = keys_ready_q;
endmodule

// File: tb/tb_kuznechik_key_schedule.sv
// Scoreboard bench for kuznechik_key_schedule using the GOST R 34.12-2015 key-schedule vector.
module tb_kuznechik_key_schedule;
  import kuznechik_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kuznechik_key_schedule_if ks();
  kuznechik_key_schedule dut (.clk(clk), .rst_n(rst_n), .ks(ks));

  typedef struct {
    logic [127:0] key;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           vld_cnt = 0;
  logic [127:0] gk [10];

  localparam logic [255:0] GOST_MK  = 256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [255:0] OTHER_MK = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0_112233445566778899aabbccddeeff00;
  localparam int EXP_LAT = 576;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit expect_key, input logic [127:0] k);
    exp_t e;
    ks.key_next = 1'b1;
    if (expect_key) begin
      e.key = k;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    tick();
    ks.key_next = 1'b0;
  endtask

  task automatic load(input logic [255:0] mk);
    ks.master_key = mk;
    ks.key_load   = 1'b1;
    tick();
    ks.key_load   = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int want);
    int n;
    n = 0;
    while (ks.keys_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'(want));
  endtask

  // Monitor: every key_valid pulse must match the oldest outstanding request.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ks.key_valid === 1'b1) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key_valid got=%h want=none", ks.round_key);
        end else begin
          e = exp_q.pop_front();
          chk("round_key", ks.round_key, e.key);
          chk("key_valid_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v0;
    ks.key_load   = 1'b0;
    ks.master_key = '0;
    ks.key_rewind = 1'b0;
    ks.key_next   = 1'b0;
`ifdef KUZ_KS_DECRYPT_ORDER_EN
    ks.key_dir    = 1'b0;
`endif
    gk[0] = 128'h8899aabbccddeeff0011223344556677;
    gk[1] = 128'hfedcba98765432100123456789abcdef;
    gk[2] = 128'hdb31485315694343228d6aef8cc78c44;
    gk[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    gk[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
    gk[5] = 128'hbd079435165c6432b532e82834da581b;
    gk[6] = 128'h51e640757e8745de705727265a0098b1;
    gk[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    gk[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    gk[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

    repeat (3) tick();
    chk("rst_round_key", ks.round_key, '0);
    chk("rst_key_valid", 128'(ks.key_valid), '0);
    chk("rst_busy", 128'(ks.busy), '0);
    chk("rst_keys_ready", 128'(ks.keys_ready), '0);
    rst_n = 1'b1;
    tick();

    v0 = vld_cnt;
    req(0, '0);
    tick();
    chk("idle_next_ignored", 128'(vld_cnt), 128'(v0));

    // GOST vector: full expansion then ten back-to-back requests and a wrap
    load(GOST_MK);
    chk("load_busy", 128'(ks.busy), 128'd1);
    chk("load_keys_ready", 128'(ks.keys_ready), '0);
    wait_ready("expansion_latency", EXP_LAT);
    chk("done_busy", 128'(ks.busy), '0);
    for (int k = 0; k < 10; k++) req(1, gk[k]);
    req(1, gk[0]);

    req(1, gk[1]);
    req(1, gk[2]);
    ks.key_rewind = 1'b1;
    req(1, gk[0]);
    ks.key_rewind = 1'b0;
    req(1, gk[1]);
    ks.key_rewind = 1'b1;
    tick();
    ks.key_rewind = 1'b0;
    req(1, gk[0]);
    repeat (3) tick();
    chk("round_key_hold", ks.round_key, gk[0]);

    // key_load beats a simultaneous key_next; key_next while busy is ignored
    v0 = vld_cnt;
    ks.key_next = 1'b1;
    load(OTHER_MK);
    ks.key_next = 1'b0;
    tick();
    chk("load_beats_next", 128'(vld_cnt), 128'(v0));
    repeat (3) req(0, '0);
    tick();
    chk("busy_next_ignored", 128'(vld_cnt), 128'(v0));
    repeat (250) tick();
    chk("iter15_busy", 128'(ks.busy), 128'd1);
    chk("iter15_keys_ready", 128'(ks.keys_ready), '0);

    load(GOST_MK);
    wait_ready("reload_latency", EXP_LAT);
    for (int k = 0; k < 10; k++) req(1, gk[k]);

    // asynchronous reset after K5 has been served
    ks.key_rewind = 1'b1;
    req(1, gk[0]);
    ks.key_rewind = 1'b0;
    for (int k = 1; k < 5; k++) req(1, gk[k]);
    repeat (2) tick();
    chk("pre_reset_round_key", ks.round_key, gk[4]);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_round_key", ks.round_key, '0);
    chk("async_rst_keys_ready", 128'(ks.keys_ready), '0);
    tick();
    rst_n = 1'b1;
    chk("post_rst_key_valid", 128'(ks.key_valid), '0);
    chk("post_rst_busy", 128'(ks.busy), '0);
    v0 = vld_cnt;
    repeat (2) req(0, '0);
    tick();
    chk("post_rst_next_ignored", 128'(vld_cnt), 128'(v0));

    load(GOST_MK);
    wait_ready("post_rst_latency", EXP_LAT);
    req(1, gk[0]);
    req(1, gk[1]);

`ifdef KUZ_KS_DECRYPT_ORDER_EN
    ks.key_dir    = 1'b1;
    ks.key_rewind = 1'b1;
    tick();
    ks.key_rewind = 1'b0;
    for (int k = 9; k >= 0; k--) req(1, gk[k]);
    req(1, gk[9]);
    ks.key_dir    = 1'b0;
    ks.key_rewind = 1'b1;
    req(1, gk[0]);
    ks.key_rewind = 1'b0;
`endif

    repeat (3) tick();
    chk("queue_drained", 128'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
